// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU: operation-select encodings,
// FSM state type/constants and small decode helpers. Nothing here depends on
// the datapath width, so every alu_mc instance shares the same package.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int MODE_W = 5;

    // Operation-select encodings
    localparam logic [MODE_W-1:0] MODE_ADD   = 5'b00000;
    localparam logic [MODE_W-1:0] MODE_SUB   = 5'b01000;
    localparam logic [MODE_W-1:0] MODE_SLL   = 5'b00001;
    localparam logic [MODE_W-1:0] MODE_SLT   = 5'b00010;
    localparam logic [MODE_W-1:0] MODE_SLTU  = 5'b00011;
    localparam logic [MODE_W-1:0] MODE_XOR   = 5'b00100;
    localparam logic [MODE_W-1:0] MODE_SRL   = 5'b00101;
    localparam logic [MODE_W-1:0] MODE_SRA   = 5'b01101;
    localparam logic [MODE_W-1:0] MODE_OR    = 5'b00110;
    localparam logic [MODE_W-1:0] MODE_AND   = 5'b00111;
    localparam logic [MODE_W-1:0] MODE_MUL   = 5'b10000;
    localparam logic [MODE_W-1:0] MODE_MULHU = 5'b10011;

    // Controller FSM state type and encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // True for the two modes served by the iterative multiplier
    function automatic logic mode_is_mul(input logic [MODE_W-1:0] m);
        return (m == MODE_MUL) || (m == MODE_MULHU);
    endfunction

    // True for every encoding listed above; anything else is flagged illegal
    function automatic logic mode_is_legal(input logic [MODE_W-1:0] m);
        logic legal;
        case (m)
            MODE_ADD, MODE_SUB, MODE_SLL, MODE_SLT, MODE_SLTU, MODE_XOR,
            MODE_SRL, MODE_SRA, MODE_OR, MODE_AND, MODE_MUL, MODE_MULHU:
                legal = 1'b1;
            default:
                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Unsigned radix-2 shift-add multiplier, one step per clock, XLEN steps.
// The first step is taken on the start edge itself so the full product is in
// prod_o, with done_o pulsing, XLEN-1 edges after start.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   start_i  in   load operands and take the first step
//   a_i      in   multiplicand (XLEN)
//   b_i      in   multiplier   (XLEN)
//   busy_o   out  steps remaining
//   done_o   out  one-cycle pulse, product valid
//   prod_o   out  full 2*XLEN product
// -----------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int XLEN = 32,
    parameter int CW   = $clog2(XLEN)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [2*XLEN-1:0]   prod_o
);

    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // One shift-add step: upper half accumulates the multiplicand when the
    // current multiplier LSB (held in the low half) is set, then the whole
    // register shifts right, keeping the carry out of the addition.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p,
                                                    input logic [XLEN-1:0]   m);
        logic [XLEN:0] sum;
        sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
        return {sum, p[XLEN-1:1]};
    endfunction

    // Next-state logic for the step counter and product register
    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start_i) begin
            mcand_d = a_i;
            prod_d  = mul_step({{XLEN{1'b0}}, b_i}, a_i);
            cnt_d   = CW'(1);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            prod_d = mul_step(prod_q, mcand_q);
            if (cnt_q == CW'(XLEN - 1)) begin
                cnt_d  = {CW{1'b0}};
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q  <= {(2*XLEN){1'b0}};
            mcand_q <= {XLEN{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign prod_o = prod_q;

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle
// operations are evaluated combinationally from the request and registered
// straight into the result register; mul/mulhu run through alu_mul_iter.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_valid   in   request present
//   in_ready   out  request accepted this cycle (IDLE only, low in reset)
//   mode       in   operation select (alu_pkg MODE_*)
//   rs1, rs2   in   operands (XLEN)
//   out_valid  out  result present (DONE only)
//   out_ready  in   consumer takes result this cycle
//   rd         out  result (XLEN)
//   illegal    out  mode was not a defined encoding
// -----------------------------------------------------------------------------
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] mode,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   rd,
    output logic              illegal
);

    state_t              state_q, state_d;
    logic [XLEN-1:0]     rd_q, rd_d;
    logic                illegal_q, illegal_d;
    logic                out_valid_q, out_valid_d;
    logic [MODE_W-1:0]   mode_q, mode_d;

    logic                in_ready_s;
    logic                accept_s;
    logic [SHW-1:0]      shamt_s;
    logic [XLEN-1:0]     alu_res_s;
    logic                mul_start_s;
    logic                mul_busy_s;
    logic                mul_done_s;
    logic [2*XLEN-1:0]   mul_prod_s;

    // in_ready is gated by reset so it reads low while reset is held and
    // rises in the first cycle after release (state is already IDLE then).
    assign in_ready_s  = (state_q == ST_IDLE) && !reset;
    assign accept_s    = in_valid && in_ready_s;
    assign mul_start_s = accept_s && mode_is_mul(mode);

    // Single-cycle operation datapath, evaluated on the live request
    always_comb begin
        shamt_s   = rs2[SHW-1:0];
        alu_res_s = {XLEN{1'b0}};
        case (mode)
            MODE_ADD:  alu_res_s = rs1 + rs2;
            MODE_SUB:  alu_res_s = rs1 - rs2;
            MODE_SLL:  alu_res_s = rs1 << shamt_s;
            MODE_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            MODE_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            MODE_XOR:  alu_res_s = rs1 ^ rs2;
            MODE_SRL:  alu_res_s = rs1 >> shamt_s;
            MODE_SRA:  alu_res_s = $signed(rs1) >>> shamt_s;
            MODE_OR:   alu_res_s = rs1 | rs2;
            MODE_AND:  alu_res_s = rs1 & rs2;
            // multiply modes are produced by alu_mul_iter; illegal modes give 0
            default:   alu_res_s = {XLEN{1'b0}};
        endcase
    end

    alu_mul_iter #(
        .XLEN (XLEN),
        .CW   (SHW)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start_i (mul_start_s),
        .a_i     (rs1),
        .b_i     (rs2),
        .busy_o  (mul_busy_s),
        .done_o  (mul_done_s),
        .prod_o  (mul_prod_s)
    );

    // Controller next-state and result-register load logic
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        mode_d      = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    mode_d = mode;
                    if (mode_is_mul(mode)) begin
                        state_d = ST_MUL;
                    end else begin
                        state_d     = ST_DONE;
                        rd_d        = alu_res_s;
                        illegal_d   = !mode_is_legal(mode);
                        out_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s && !mul_busy_s) begin
                    state_d     = ST_DONE;
                    rd_d        = (mode_q == MODE_MULHU) ? mul_prod_s[2*XLEN-1:XLEN]
                                                         : mul_prod_s[XLEN-1:0];
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                // Result stays frozen until taken; no request can be accepted
                // in this cycle because in_ready only rises once back in IDLE.
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rd_d        = {XLEN{1'b0}};
                illegal_d   = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Controller and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_q        <= {XLEN{1'b0}};
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            mode_q      <= {MODE_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            mode_q      <= mode_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign rd        = rd_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
// Self-checking bench for alu_mc (XLEN=32): directed corner cases followed by
// randomized requests, all compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_alu_mc;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        mode;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   rd;
    logic              illegal;

    int n_checks = 0;
    int n_errors = 0;

    alu_mc #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: result, illegal flag and accept-to-out_valid latency
    task automatic ref_model(input logic [4:0] m, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic ill, output int lat);
        logic [63:0] p;
        int sh;
        p   = {32'd0, a} * {32'd0, b};
        sh  = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        case (m)
            5'b00000: r = a + b;
            5'b01000: r = a - b;
            5'b00001: r = a << sh;
            5'b00010: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5'b00011: r = (a < b) ? 32'd1 : 32'd0;
            5'b00100: r = a ^ b;
            5'b00101: r = a >> sh;
            5'b01101: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            5'b00110: r = a | b;
            5'b00111: r = a & b;
            5'b10000: begin r = p[31:0];  lat = 33; end
            5'b10011: begin r = p[63:32]; lat = 33; end
            default:  begin r = 32'd0; ill = 1'b1; end
        endcase
    endtask

    // Issue one request, check latency/result, hold the result for 'hold'
    // cycles (optionally with junk requests on the input), then take it.
    task automatic run_op(input logic [4:0] m, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit noisy, output logic [31:0] got);
        logic [31:0] er;
        logic        ei;
        int          elat;
        int          lat;
        ref_model(m, a, b, er, ei, elat);
        lat = 0;
        while (!in_ready && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("in_ready_before", 64'(in_ready), 64'd1);
        in_valid = 1'b1; mode = m; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; mode = 5'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        got = rd;
        check_eq("latency", 64'(lat), 64'(elat));
        check_eq("rd", 64'(rd), 64'(er));
        check_eq("illegal", 64'(illegal), 64'(ei));
        for (int i = 0; i < hold; i++) begin
            if (noisy) begin
                in_valid = 1'b1; mode = 5'b00000; rs1 = $urandom; rs2 = $urandom;
            end
            @(posedge clk); #1;
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_rd", 64'(rd), 64'(er));
            check_eq("hold_illegal", 64'(illegal), 64'(ei));
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("release_valid", 64'(out_valid), 64'd0);
        check_eq("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    logic [4:0] mode_tab [12] = '{5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                  5'b00101, 5'b01101, 5'b00110, 5'b00111, 5'b10000, 5'b10011};

    initial begin
        logic [31:0] got;
        logic [4:0]  m;
        logic [31:0] a;
        logic [31:0] b;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        mode = 5'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_rd", 64'(rd), 64'd0);
        check_eq("rst_illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed corner cases
        run_op(5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0, got);
        check_eq("add_wrap", 64'(got), 64'h0);
        run_op(5'b01101, 32'h8000_0000, 32'h0000_0024, 0, 1'b0, got);
        check_eq("sra_shamt4", 64'(got), 64'hF800_0000);
        run_op(5'b00010, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0, got);
        check_eq("slt_neg", 64'(got), 64'h1);
        run_op(5'b00011, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0, got);
        check_eq("sltu_big", 64'(got), 64'h0);
        run_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, got);
        check_eq("mulhu_max", 64'(got), 64'hFFFF_FFFE);
        run_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, got);
        check_eq("mul_max", 64'(got), 64'h1);
        run_op(5'b10011, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, got);
        check_eq("mulhu_zero", 64'(got), 64'h0);
        run_op(5'b01111, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, got);
        check_eq("illegal_rd", 64'(got), 64'h0);

        // Backpressure with junk requests presented during DONE and handshake
        run_op(5'b01000, 32'h0000_0010, 32'h0000_0003, 5, 1'b1, got);
        check_eq("bp_sub", 64'(got), 64'hD);

        // Reset in cycle 10 of a multiply
        in_valid = 1'b1; mode = 5'b10000; rs1 = 32'h1234_5678; rs2 = 32'h0000_0077;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mid_mul_rst_valid", 64'(out_valid), 64'd0);
        check_eq("mid_mul_rst_rd", 64'(rd), 64'd0);
        check_eq("mid_mul_rst_illegal", 64'(illegal), 64'd0);
        check_eq("mid_mul_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mid_mul_post_in_ready", 64'(in_ready), 64'd1);
        repeat (35) @(posedge clk);
        #1;
        check_eq("no_ghost_result", 64'(out_valid), 64'd0);
        run_op(5'b00000, 32'd2, 32'd3, 0, 1'b0, got);
        check_eq("add_after_rst", 64'(got), 64'd5);

        // Reset while an illegal result waits in DONE
        in_valid = 1'b1; mode = 5'b11111; rs1 = 32'd1; rs2 = 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("ill_done_valid", 64'(out_valid), 64'd1);
        check_eq("ill_done_flag", 64'(illegal), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("done_rst_valid", 64'(out_valid), 64'd0);
        check_eq("done_rst_illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Randomized requests
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 7) == 0) m = 5'($urandom);
            else                           m = mode_tab[$urandom_range(0, 11)];
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_FFFF;
                1:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(0, 40));
                default: b = $urandom;
            endcase
            run_op(m, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), meaning shift-amount width taken from rs2[SHW-1:0].
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port mode  input  5  operation select (encodings in REQ-013).
REQ-008 SHALL have port rs1  input  XLEN  operand A.
REQ-009 SHALL have port rs2  input  XLEN  operand B.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port rd  output  XLEN  result; port illegal  output  1  mode not in REQ-013.

Function
REQ-013 SHALL decode mode: 00000 add, 01000 sub, 00001 sll, 00010 slt, 00011 sltu, 00100 xor, 00101 srl, 01101 sra, 00110 or, 00111 and, 10000 mul (low XLEN bits), 10011 mulhu (high XLEN bits, unsigned); all other codes illegal.
REQ-014 SHALL implement FSM states IDLE, MUL, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept a request when in_valid && in_ready, capturing mode, rs1, rs2 in that cycle.
REQ-016 SHALL, for non-multiply and illegal modes, compute the result on accept and enter DONE next cycle (out_valid one cycle after accept).
REQ-017 SHALL, for mul/mulhu, enter MUL, run one shift-add step per cycle for exactly XLEN cycles, then enter DONE (out_valid XLEN+1 cycles after accept).
REQ-018 SHALL hold rd, illegal, out_valid stable in DONE until out_ready=1, then return to IDLE next cycle; no new request is accepted in the handshake cycle.
REQ-019 SHALL wrap add/sub/mul modulo 2^XLEN; shifts use rs2[SHW-1:0] only; sra replicates rs1[XLEN-1].
REQ-020 SHALL return slt/sltu as 1 or 0 zero-extended to XLEN.
REQ-021 SHALL, for illegal mode, return rd=0 with illegal=1 through the normal DONE handshake; illegal=0 for all legal modes.
REQ-022 SHALL ignore in_valid, mode, rs1, rs2 while not in IDLE.
REQ-023 SHALL produce mulhu of 0 operands as 0 and retain full 2*XLEN product internally.

Reset
REQ-024 SHALL, on reset assertion at any time (including mid-MUL or DONE), immediately force state IDLE, rd=0, illegal=0, out_valid=0, and discard any in-flight operation.
REQ-025 SHALL drive in_ready=0 while reset is asserted and 1 in the first cycle after deassertion.

Structure
REQ-026 SHALL place mode encodings, FSM state type, and XLEN-independent constants in shared package alu_pkg.
REQ-027 SHALL implement the iterative multiplier as sub-module alu_mul_iter (start, operands in; busy, done, 2*XLEN product out; XLEN-cycle count).
REQ-028 SHALL implement single-cycle operations combinationally inside alu_mc, registering only into the DONE result register.

Verification (XLEN=32)
REQ-029 SHALL verify add 0xFFFFFFFF+0x00000001 -> rd=0x00000000, out_valid exactly 1 cycle after accept.
REQ-030 SHALL verify sra rs1=0x80000000, rs2=0x00000024 (shamt 4) -> rd=0xF8000000; slt 0xFFFFFFFF vs 0x00000001 -> rd=1; sltu same operands -> rd=0.
REQ-031 SHALL verify mulhu 0xFFFFFFFF*0xFFFFFFFF -> rd=0xFFFFFFFE, out_valid at cycle 33 after accept; mul same operands -> rd=0x00000001.
REQ-032 SHALL verify backpressure: hold out_ready=0 for 5 cycles after result -> rd and out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-033 SHALL verify reset asserted at cycle 10 of a mul -> outputs zero immediately, in_ready=1 after deassertion, subsequent add 2+3 -> rd=5.
REQ-034 SHALL verify mode 01111 -> rd=0, illegal=1, completed via normal handshake.
